// File: rtl/gray_pkg.sv
// Shared types for the Gray position tracker: FSM state encoding and the
// classification of one observed change of the binary position.
package gray_pkg;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } gray_trk_state_e;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } gray_step_e;

endpackage : gray_pkg

// File: rtl/gray_step_tracker_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
  parameter int width_p = 5
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] bin_o
);

  logic [width_p-1:0] bin;

  always_comb begin
    bin = '0;
    bin[width_p-1] = gray_i[width_p-1];
    for (int i = width_p - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray_i[i];
    end
  end

  assign bin_o = bin;

endmodule : gray2bin

// File: rtl/gray_step_tracker.sv
// Tracks a Gray-coded position source, accumulates +1/-1 steps and posts step
// events on a valid/ready interface. Define GRAY_TRACKER_FILTER_EN to add a
// two-sample stability filter in front of the converter (one extra cycle).
module gray_step_tracker
  import gray_pkg::*;
#(
  parameter int width_p     = 5,
  parameter int pos_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic [width_p-1:0]     gray_i,
  output logic [pos_width_p-1:0] pos_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   dir_o,
  output logic                   coalesced_o,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  gray_trk_state_e    state;
  gray_step_e         step;
  logic [width_p-1:0] gray_r;
  logic [width_p-1:0] bin_cur;
  logic [width_p-1:0] bin_prev;
  logic [width_p-1:0] delta;
  logic               handshake;

  // NOTE: the input register is loaded from gray_i even during reset rather
  // than cleared, so the SYNC state baselines on the real source position.
`ifdef GRAY_TRACKER_FILTER_EN
  logic [width_p-1:0] gray_s1;

  always_ff @(posedge clk_i) begin
    gray_s1 <= gray_i;
    if (reset_i || (gray_i == gray_s1)) begin
      gray_r <= gray_i;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    gray_r <= gray_i;
  end
`endif

  gray2bin #(.width_p(width_p)) u_gray2bin (
    .gray_i (gray_r),
    .bin_o  (bin_cur)
  );

  assign delta     = bin_cur - bin_prev;
  assign handshake = valid_o & ready_i;

  always_comb begin
    step = STEP_NONE;
    if ((state == TRACK) && en_i) begin
      if (delta == width_p'(1)) begin
        step = STEP_UP;
      end else if (delta == '1) begin
        step = STEP_DOWN;
      end else if (delta != '0) begin
        step = STEP_ILLEGAL;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= SYNC;
      bin_prev    <= '0;
      pos_o       <= '0;
      valid_o     <= 1'b0;
      dir_o       <= 1'b0;
      coalesced_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      // Baseline follows the source every cycle, so an illegal jump resyncs.
      bin_prev <= bin_cur;
      if (state == SYNC) begin
        state <= TRACK;
      end

      if (step == STEP_UP) begin
        pos_o <= pos_o + pos_width_p'(1);
        dir_o <= 1'b1;
      end else if (step == STEP_DOWN) begin
        pos_o <= pos_o - pos_width_p'(1);
        dir_o <= 1'b0;
      end

      if ((step == STEP_UP) || (step == STEP_DOWN)) begin
        valid_o     <= 1'b1;
        coalesced_o <= valid_o & ~ready_i;
      end else if (handshake) begin
        valid_o     <= 1'b0;
        coalesced_o <= 1'b0;
      end

      // A new illegal jump outranks a clear in the same cycle.
      if (step == STEP_ILLEGAL) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule : gray_step_tracker

// File: tb/tb_gray_step_tracker.sv
// Directed bench for gray_step_tracker: table of held input vectors with
// hand-computed outputs, plus hand-written multi-cycle handshake/reset cases.
module tb_gray_step_tracker;

`ifdef GRAY_TRACKER_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic [4:0]  gray_i;
  logic [15:0] pos_o;
  logic        valid_o;
  logic        ready_i;
  logic        dir_o;
  logic        coalesced_o;
  logic        err_o;
  logic        err_clr_i;

  int checks = 0;
  int errors = 0;

  gray_step_tracker #(.width_p(5), .pos_width_p(16)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .gray_i      (gray_i),
    .pos_o       (pos_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .dir_o       (dir_o),
    .coalesced_o (coalesced_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  g;
    logic        en;
    logic        rdy;
    logic        clr;
    logic [15:0] pos;
    logic        valid;
    logic        dir;
    logic        coal;
    logic        err;
  } vec_t;

  vec_t vecs [19];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] pos, input logic valid,
                           input logic dir, input logic coal, input logic err);
    check({tag, " pos"},   pos_o, pos);
    check({tag, " valid"}, 16'(valid_o), 16'(valid));
    check({tag, " dir"},   16'(dir_o), 16'(dir));
    check({tag, " coal"},  16'(coalesced_o), 16'(coal));
    check({tag, " err"},   16'(err_o), 16'(err));
  endtask

  initial begin
    //             gray      en    rdy   clr   pos       valid dir   coal  err
    vecs[0]  = '{5'b00001, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{5'b00011, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{5'b00001, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'b00000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'b10000, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'b00000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{5'b00000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{5'b00001, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{5'b00011, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{5'b00010, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{5'b00010, 1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{5'b00110, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{5'b00111, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{5'b00100, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{5'b00100, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{5'b00000, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{5'b00000, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{5'b00011, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{5'b00011, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0};

    reset_i   = 1'b1;
    en_i      = 1'b1;
    gray_i    = 5'b00000;
    ready_i   = 1'b1;
    err_clr_i = 1'b0;
    tick(2);
    reset_i = 1'b0;
    tick(10);
    check_all("reset idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Each vector is held long enough for its change to reach the outputs.
    for (int i = 0; i < 19; i++) begin
      gray_i    = vecs[i].g;
      en_i      = vecs[i].en;
      ready_i   = vecs[i].rdy;
      err_clr_i = vecs[i].clr;
      tick(LAT);
      check_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].valid, vecs[i].dir,
                vecs[i].coal, vecs[i].err);
    end
    err_clr_i = 1'b0;

    // Two unaccepted events build a coalesced event.
    ready_i = 1'b0;
    gray_i  = 5'b00010;
    tick(LAT);
    check_all("pend first", 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0);
    gray_i = 5'b00110;
    tick(LAT);
    check_all("pend coal", 16'h0006, 1'b1, 1'b1, 1'b1, 1'b0);

    // Handshake and a new event on the same edge: valid stays, coalesced drops.
    gray_i = 5'b00111;
    tick(LAT - 1);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    check_all("hs+event", 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0);

    // Single-cycle ready with no event retires the pending event.
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    check_all("hs only", 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0);

    // Mid-operation reset discards a pending down-step event.
    gray_i = 5'b00110;
    tick(LAT);
    check_all("pend down", 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b1;
    tick(1);
    check_all("mid reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b0;
    tick(4);
    check_all("resync", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    gray_i = 5'b00111;
    tick(LAT);
    check_all("post resync", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef GRAY_TRACKER_FILTER_EN
    // One-cycle glitch must be rejected by the stability filter.
    gray_i = 5'b00110;
    tick(1);
    gray_i = 5'b00111;
    tick(6);
    check_all("glitch", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gray_step_tracker
